// File: rtl/uart_rx_axis.sv
// UART receiver with 8x oversampling and a run-time prescaler, delivering
// each received word on an AXI-stream master port with framing/overrun flags.
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rxd_i,
  input  logic [15:0]           prescale_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  busy_o,
  output logic                  overrun_error_o,
  output logic                  frame_error_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [1:0]            r_rxd_sync;
  logic [2:0]            r_state;
  logic [18:0]           r_timer;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [15:0]           r_prescale;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_overrun;
  logic                  r_frame;

  logic                  w_rxd_s;
  logic [15:0]           w_p_in;
  logic [18:0]           w_half_load;
  logic [18:0]           w_bit_load;
  logic                  w_timer_done;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rxd_sync <= 2'b11;
    end else begin
      r_rxd_sync <= {r_rxd_sync[0], rxd_i};
    end
  end

  assign w_rxd_s      = r_rxd_sync[1];
  assign w_p_in       = (prescale_i == 16'd0) ? 16'd1 : prescale_i;
  assign w_half_load  = {1'b0, w_p_in, 2'b00} - 19'd1;
  assign w_bit_load   = {r_prescale, 3'b000} - 19'd1;
  assign w_timer_done = (r_timer == 19'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_prescale <= 16'd1;
      r_shift    <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_overrun  <= 1'b0;
      r_frame    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
      if (r_tvalid && m_axis_tready_i) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            r_prescale <= w_p_in;
            r_timer    <= w_half_load;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (!w_timer_done) begin
            r_timer <= r_timer - 19'd1;
          end else if (!w_rxd_s) begin
            r_timer   <= w_bit_load;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (!w_timer_done) begin
            r_timer <= r_timer - 19'd1;
          end else begin
            r_shift <= {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
            r_timer <= w_bit_load;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end

        S_STOP: begin
          if (!w_timer_done) begin
            r_timer <= r_timer - 19'd1;
          end else if (w_rxd_s) begin
            // A handshake on this same edge frees the slot, so no overrun then.
            if (r_tvalid && !m_axis_tready_i) begin
              r_overrun <= 1'b1;
            end else begin
              r_tdata  <= r_shift;
              r_tvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_frame <= 1'b1;
            r_state <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (w_rxd_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign busy_o          = (r_state != S_IDLE);
  assign overrun_error_o = r_overrun;
  assign frame_error_o   = r_frame;

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

UART receiver that deserialises the asynchronous `rxd_i` line into bytes and presents them on an AXI-stream master port. It sits directly upstream of the ALU command parser, which consumes opcode, length and operand bytes through a valid/ready handshake. The block uses 8x oversampling with a run-time `prescale_i` and flags framing and overrun errors.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame (LSB first, no parity, one stop bit).
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `rxd_i`  in  1  serial input; idle high; asynchronous to `clk_i`.
- `prescale_i`  in  16  clocks per 1/8 bit; the bit period is 8·P cycles.
- `m_axis_tdata_o`  out  DATA_WIDTH  received byte.
- `m_axis_tvalid_o`  out  1  byte available.
- `m_axis_tready_i`  in  1  consumer accepts the byte.
- `busy_o`  out  1  a frame is in progress (FSM not in IDLE).
- `overrun_error_o`  out  1  one-cycle pulse: a byte was dropped.
- `frame_error_o`  out  1  one-cycle pulse: the stop bit was sampled low.

## Operation
- `rxd_i` passes through a 2-flop synchronizer; both flops reset to 1. The output of this synchronizer is `rxd_s`.
- P is latched from `prescale_i` at start detection. Changes during a frame are ignored. A value of 0 is treated as 1.
- Bit-timer width is 19 bits. Bit counter is log2(DATA_WIDTH)+1 bits.
- FSM states:
  - IDLE: when `rxd_s`=0, latch P, load the timer with 4P−1, and go to START.
  - START: decrement the timer. At 0, sample `rxd_s`:
    - If 0, load the timer with 8P−1, clear the bit count, and go to DATA.
    - If 1 (glitch), go to IDLE with no output and no error.
  - DATA: decrement the timer. At 0, shift `rxd_s` into the MSB of the shift register (LSB-first framing) and reload 8P−1. After DATA_WIDTH samples, go to STOP.
  - STOP: decrement the timer. At 0, sample `rxd_s`:
    - If 1 (good frame): if `tvalid` is high and `tready` is low, pulse `overrun_error_o`, drop the new byte, and leave `tdata` unchanged. Otherwise load `tdata` and set `tvalid`. Go to IDLE.
    - If 0 (bad frame): pulse `frame_error_o`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxd_s`=1, then go to IDLE. This prevents a break condition from retriggering the receiver.
- Output handshake:
  - `tvalid` clears on the cycle after `tvalid`&`tready`.
  - `tdata` is stable while `tvalid` is high and not yet accepted.
- Simultaneous events:
  - A handshake on the same edge as a good stop sample transfers the old byte and loads the new one, with no overrun.
  - `tvalid` stays high in that case.
- Reset:
  - Asynchronous; applies immediately, including mid-frame.
  - Outputs reset to `tdata`=0, `tvalid`=0, `busy`=0, both error outputs 0.
  - FSM resets to IDLE, timer and bit count to 0.

## Timing
- Let j be the first rising edge at which `rxd_i` is low. The FSM sees `rxd_s`=0 at edge k=j+2.
- Sample points, counted from k:
  - start bit at k+4P;
  - data bit i at k+4P+8P·(i+1), for i = 0..DATA_WIDTH−1;
  - stop bit at k+4P+8P·(DATA_WIDTH+1).
- `tvalid`, `frame_error` and `overrun_error` are registered at the stop-sample edge and are visible in the following cycle.
- `busy_o` is high from edge k through the stop-sample edge, and through WAIT_IDLE when that state is entered.
- There is no combinational path from `m_axis_tready_i` to any output.
- A following start bit is detected 1 cycle after the return to IDLE. Back-to-back frames with a 1-bit stop are received with no loss.

## Test plan
All scenarios use P=2 (16 cycles per bit) and DATA_WIDTH=8.
- Send 0xEC with `tready`=1 → `tvalid` is high for exactly 1 cycle with `tdata`=0xEC, rising after edge j+154; no errors are flagged.
- Send 0xAD then 0x03 back-to-back with `tready`=0 → `tdata` holds 0xAD. At the 0x03 stop sample, `overrun_error_o` pulses for 1 cycle. Raising `tready` then transfers 0xAD once, and `tvalid` drops.
- Send 0x55 with the stop bit driven low, then hold `rxd_i` low for 100 cycles → `frame_error_o` pulses once, `tvalid` stays 0, and `busy_o` stays high until `rxd_i` returns high. The next frame 0x3C is received correctly.
- Drive a low pulse of 5 cycles on `rxd_i` (shorter than 4P=8) → no `tvalid`, no error, and `busy_o` returns to 0 after the start sample.
- Assert `rst_ni`=0 asynchronously mid-data-bit → all outputs read 0 before the next clock edge. After release, byte 0xA5 is received correctly.
- Send 0x11 then 0x22 back-to-back, with `tready` asserted on exactly the edge of the 0x22 stop sample → 0x11 transfers, `tdata` becomes 0x22 with `tvalid` still high, and no overrun is flagged.
